// File: rtl/cmd_sender.sv
// Command-link transmitter: go/stop requests become command bytes sent as 8N1 UART frames.
// Optional build macro STOP_PREEMPT_EN lets a STOP overwrite a pending GO instead of dropping.
module cmd_sender #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_go,
  input  logic       send_stop,
  input  logic [5:0] dest_ID,
  output logic       TX,
  output logic       rdy,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       cmd_drop
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  state_e           state_q, state_d;
  logic             pendValid_q, pendValid_d;
  logic [7:0]       pendByte_q, pendByte_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic             cmdDrop_q, cmdDrop_d;

  logic             bitEnd;
  logic             reqValid;
  logic [7:0]       reqByte;
  logic             slotFree;

  assign bitEnd   = (baudCnt_q == BAUD_LAST);
  assign reqValid = send_go | send_stop;
  assign reqByte  = send_stop ? 8'h00 : {2'b01, dest_ID};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pendValid_q <= 1'b0;
      pendByte_q  <= 8'h00;
      shift_q     <= 8'h00;
      baudCnt_q   <= '0;
      bitCnt_q    <= 3'd0;
      cmdDrop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pendValid_q <= pendValid_d;
      pendByte_q  <= pendByte_d;
      shift_q     <= shift_d;
      baudCnt_q   <= baudCnt_d;
      bitCnt_q    <= bitCnt_d;
      cmdDrop_q   <= cmdDrop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pendValid_d = pendValid_q;
    pendByte_d  = pendByte_q;
    shift_d     = shift_q;
    baudCnt_d   = baudCnt_q;
    bitCnt_d    = bitCnt_q;
    cmdDrop_d   = 1'b0;
    slotFree    = !pendValid_q;

    if (state_q != IDLE) begin
      baudCnt_d = bitEnd ? '0 : baudCnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (pendValid_q) begin
          shift_d     = pendByte_q;
          pendValid_d = 1'b0;
          baudCnt_d   = '0;
          state_d     = START;
          slotFree    = 1'b1;
        end
      end
      START: begin
        if (bitEnd) begin
          bitCnt_d = 3'd0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (bitEnd) begin
          shift_d  = shift_q >> 1;
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bitEnd) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture runs after the FSM so a request can refill the slot on the load edge.
    if (reqValid) begin
      if (slotFree) begin
        pendValid_d = 1'b1;
        pendByte_d  = reqByte;
      end else begin
`ifdef STOP_PREEMPT_EN
        if (send_stop && (pendByte_q[7:6] == 2'b01)) begin
          pendByte_d = 8'h00;
        end else begin
          cmdDrop_d = 1'b1;
        end
`else
        cmdDrop_d = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    TX = 1'b1;
    unique case (state_q)
      START:   TX = 1'b0;
      DATA:    TX = shift_q[0];
      default: TX = 1'b1;
    endcase
  end

  assign rdy      = !pendValid_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = (state_q == STOP) && bitEnd;
  assign cmd_drop = cmdDrop_q;

endmodule

// File: tb/tb_cmd_sender.sv
// Bench for cmd_sender: UART frame monitor with an expected-byte scoreboard, vector table and corner sequences.
module tb_cmd_sender;

  localparam int BD = 4;

  typedef struct {
    logic       go;
    logic       stop;
    logic [5:0] id;
    logic [7:0] expByte;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send_go = 1'b0;
  logic       send_stop = 1'b0;
  logic [5:0] dest_ID = 6'd0;
  logic       TX, rdy, tx_busy, tx_done, cmd_drop;

  int compared = 0;
  int mismatched = 0;
  int dropCount = 0;
  int doneCount = 0;
  int frameCount = 0;
  logic [7:0] expQ[$];

  cmd_sender #(.BAUD_DIV(BD), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .send_go(send_go), .send_stop(send_stop),
    .dest_ID(dest_ID), .TX(TX), .rdy(rdy), .tx_busy(tx_busy),
    .tx_done(tx_done), .cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller sits just after a falling edge; the request is seen by exactly one rising edge.
  task automatic applyStimulus(input logic go, input logic stop, input logic [5:0] id);
    send_go = go;
    send_stop = stop;
    dest_ID = id;
    @(negedge clk);
    send_go = 1'b0;
    send_stop = 1'b0;
    dest_ID = 6'd0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (n < budget && !(expQ.size() == 0 && !tx_busy && rdy)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle wait", 32'(n < budget), 32'd1);
  endtask

  always @(negedge clk) begin
    if (cmd_drop) dropCount++;
    if (tx_done) doneCount++;
  end

  // Frame receiver: samples each bit mid-period and scores it against the queue.
  initial begin
    logic [7:0] rx;
    logic [7:0] exp;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst_n && TX === 1'b0) begin
        aborted = 1'b0;
        rx = 8'h00;
        repeat (BD/2 - 1) @(negedge clk);
        if (!rst_n) aborted = 1'b1;
        else checkOutput("start bit", 32'(TX), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          rx[i] = TX;
        end
        repeat (BD) @(negedge clk);
        if (!rst_n) aborted = 1'b1;
        if (!aborted) begin
          checkOutput("stop bit", 32'(TX), 32'd1);
          frameCount++;
          if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected frame: got %0h expected none", rx);
          end else begin
            exp = expQ.pop_front();
            checkOutput("frame byte", 32'(rx), 32'(exp));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [7:0] b;
    logic expTx;
    int d0, r0, f0;

    vecs[0] = '{1'b1, 1'b0, 6'h2A, 8'h6A};
    vecs[1] = '{1'b1, 1'b0, 6'h00, 8'h40};
    vecs[2] = '{1'b1, 1'b0, 6'h3F, 8'h7F};
    vecs[3] = '{1'b1, 1'b0, 6'h15, 8'h55};
    vecs[4] = '{1'b0, 1'b1, 6'h2A, 8'h00};
    vecs[5] = '{1'b1, 1'b1, 6'h05, 8'h00};

    repeat (3) @(negedge clk);
    checkOutput("reset TX", 32'(TX), 32'd1);
    checkOutput("reset rdy", 32'(rdy), 32'd1);
    checkOutput("reset tx_busy", 32'(tx_busy), 32'd0);
    checkOutput("reset tx_done", 32'(tx_done), 32'd0);
    checkOutput("reset cmd_drop", 32'(cmd_drop), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single GO cycle-exact frame");
    b = 8'h6A;
    d0 = doneCount;
    expQ.push_back(b);
    applyStimulus(1'b1, 1'b0, 6'h2A);
    checkOutput("capture rdy", 32'(rdy), 32'd0);
    checkOutput("TX before start", 32'(TX), 32'd1);
    for (int j = 1; j <= 10*BD; j++) begin
      @(negedge clk);
      if (j <= BD) expTx = 1'b0;
      else if (j <= 9*BD) expTx = b[(j - BD - 1) / BD];
      else expTx = 1'b1;
      checkOutput($sformatf("frame cycle %0d {TX,done,busy}", j),
                  32'({TX, tx_done, tx_busy}), 32'({expTx, (j == 10*BD), 1'b1}));
    end
    @(negedge clk);
    checkOutput("busy after frame", 32'(tx_busy), 32'd0);
    waitIdle(100);
    checkOutput("single done pulses", 32'(doneCount - d0), 32'd1);

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) begin
      d0 = doneCount;
      r0 = dropCount;
      f0 = frameCount;
      expQ.push_back(vecs[i].expByte);
      applyStimulus(vecs[i].go, vecs[i].stop, vecs[i].id);
      waitIdle(200);
      checkOutput($sformatf("vec %0d frames", i), 32'(frameCount - f0), 32'd1);
      checkOutput($sformatf("vec %0d drops", i), 32'(dropCount - r0), 32'd0);
      checkOutput($sformatf("vec %0d done", i), 32'(doneCount - d0), 32'd1);
    end

    $display("[TB] queueing two GOs");
    f0 = frameCount;
    expQ.push_back(8'h41);
    applyStimulus(1'b1, 1'b0, 6'h01);
    checkOutput("queue rdy after capture", 32'(rdy), 32'd0);
    @(negedge clk);
    checkOutput("queue rdy after load", 32'(rdy), 32'd1);
    expQ.push_back(8'h42);
    applyStimulus(1'b1, 1'b0, 6'h02);
    checkOutput("queue rdy second capture", 32'(rdy), 32'd0);
    repeat (9*BD - 2) @(negedge clk);
    begin
      int hi = 0;
      int n = 0;
      @(negedge clk);
      while (TX === 1'b1 && n < 20) begin
        hi++;
        n++;
        @(negedge clk);
      end
      checkOutput("inter-frame gap", 32'(hi), 32'(BD + 1));
    end
    waitIdle(200);
    checkOutput("queue frames", 32'(frameCount - f0), 32'd2);

    $display("[TB] overflow");
    f0 = frameCount;
    r0 = dropCount;
    expQ.push_back(8'h41);
    applyStimulus(1'b1, 1'b0, 6'h01);
    @(negedge clk);
    expQ.push_back(8'h42);
    applyStimulus(1'b1, 1'b0, 6'h02);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 6'h03);
    checkOutput("overflow cmd_drop", 32'(cmd_drop), 32'd1);
    @(negedge clk);
    checkOutput("overflow drop width", 32'(cmd_drop), 32'd0);
    waitIdle(300);
    checkOutput("overflow frames", 32'(frameCount - f0), 32'd2);
    checkOutput("overflow drops", 32'(dropCount - r0), 32'd1);

    $display("[TB] stop against pending GO");
    f0 = frameCount;
    r0 = dropCount;
    expQ.push_back(8'h41);
    applyStimulus(1'b1, 1'b0, 6'h01);
    @(negedge clk);
`ifndef STOP_PREEMPT_EN
    expQ.push_back(8'h43);
`endif
    applyStimulus(1'b1, 1'b0, 6'h03);
    @(negedge clk);
`ifdef STOP_PREEMPT_EN
    expQ.push_back(8'h00);
`endif
    applyStimulus(1'b0, 1'b1, 6'h00);
    waitIdle(300);
    checkOutput("preempt frames", 32'(frameCount - f0), 32'd2);
`ifdef STOP_PREEMPT_EN
    checkOutput("preempt drops", 32'(dropCount - r0), 32'd0);
`else
    checkOutput("preempt drops", 32'(dropCount - r0), 32'd1);
`endif

    $display("[TB] reset mid-frame");
    f0 = frameCount;
    expQ.push_back(8'h6A);
    applyStimulus(1'b1, 1'b0, 6'h2A);
    repeat (4*BD + 2) @(negedge clk);
    checkOutput("pre-reset in data", 32'(tx_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset TX async", 32'(TX), 32'd1);
    checkOutput("reset busy async", 32'(tx_busy), 32'd0);
    checkOutput("reset rdy async", 32'(rdy), 32'd1);
    expQ.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    begin
      int lows = 0;
      int busy = 0;
      repeat (60) begin
        @(negedge clk);
        if (TX !== 1'b1) lows++;
        if (tx_busy !== 1'b0) busy++;
      end
      checkOutput("post-reset TX low cycles", 32'(lows), 32'd0);
      checkOutput("post-reset busy cycles", 32'(busy), 32'd0);
    end
    checkOutput("post-reset frames", 32'(frameCount - f0), 32'd0);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
